// File: rtl/datapath_pkg.sv
// Shared types and constants for the single-bus datapath: width, ALU op encoding
// in strobe priority order, and bus-source indices in bus priority order.
package datapath_pkg;

    localparam int DATA_W  = 32;
    localparam int Z_W     = 2 * DATA_W;
    localparam int NUM_GPR = 16;
    localparam int NUM_OPS = 13;

    // Encoding equals the strobe bit index; OP_INC is the no-strobe fallback.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SHR  = 4'd2,
        OP_SHRA = 4'd3,
        OP_SHL  = 4'd4,
        OP_ROR  = 4'd5,
        OP_ROL  = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_MUL  = 4'd9,
        OP_DIV  = 4'd10,
        OP_NEG  = 4'd11,
        OP_NOT  = 4'd12,
        OP_INC  = 4'd13
    } alu_op_e;

    // Lower index wins when several sources drive the bus at once.
    localparam int SRC_R0   = 0;
    localparam int SRC_HI   = 16;
    localparam int SRC_LO   = 17;
    localparam int SRC_ZHI  = 18;
    localparam int SRC_ZLO  = 19;
    localparam int SRC_PC   = 20;
    localparam int SRC_MDR  = 21;
    localparam int NUM_SRC  = 22;

    function automatic alu_op_e pick_op(input logic [NUM_OPS-1:0] strobes);
        alu_op_e op;
        op = OP_INC;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (strobes[i]) op = alu_op_e'(i[3:0]);
        end
        return op;
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: a comes from Y, b from the bus; 64-bit result feeds Z.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [NUM_OPS-1:0] op_strobes,
    output logic [Z_W-1:0]     c
);

    alu_op_e                  op;
    logic [4:0]               sh;
    logic [5:0]               sh_inv;
    logic signed [Z_W-1:0]    prod;
    logic signed [DATA_W-1:0] quot;
    logic signed [DATA_W-1:0] rem;

    assign op     = pick_op(op_strobes);
    assign sh     = b[4:0];
    assign sh_inv = 6'd32 - {1'b0, sh};
    assign prod   = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});

    // Divide-by-zero and MIN/-1 are pinned explicitly so no simulator or
    // synthesis tool has to guess at them.
    always_comb begin
        quot = '1;
        rem  = $signed(a);
        if (b == '0) begin
            quot = '1;
            rem  = $signed(a);
        end else if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1) begin
            quot = $signed(a);
            rem  = '0;
        end else begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        c = '0;
        case (op)
            OP_ADD:  c = {{DATA_W{1'b0}}, a + b};
            OP_SUB:  c = {{DATA_W{1'b0}}, a - b};
            OP_SHR:  c = {{DATA_W{1'b0}}, a >> sh};
            OP_SHRA: c = {{DATA_W{1'b0}}, $signed(a) >>> sh};
            OP_SHL:  c = {{DATA_W{1'b0}}, a << sh};
            OP_ROR:  c = {{DATA_W{1'b0}}, (a >> sh) | (a << sh_inv)};
            OP_ROL:  c = {{DATA_W{1'b0}}, (a << sh) | (a >> sh_inv)};
            OP_AND:  c = {{DATA_W{1'b0}}, a & b};
            OP_OR:   c = {{DATA_W{1'b0}}, a | b};
            OP_MUL:  c = prod;
            OP_DIV:  c = {rem, quot};
            OP_NEG:  c = {{DATA_W{1'b0}}, -b};
            OP_NOT:  c = {{DATA_W{1'b0}}, ~b};
            default: c = {{DATA_W{1'b0}}, b + 1'b1};
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux and ALU.
// Optional DATAPATH_R0_ZERO_EN makes R0out drive a hardwired zero.
module datapath #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                HIin,
    input  logic                HIout,
    input  logic                LOin,
    input  logic                LOout,
    input  logic                PCin,
    input  logic                PCout,
    input  logic                IRin,
    input  logic                Zin,
    input  logic                Zhighout,
    input  logic                Zlowout,
    input  logic                Yin,
    input  logic                MARin,
    input  logic                MDRin,
    input  logic                MDRout,
    input  logic                Read,
    input  logic [DATA_W-1:0]   Mdatain,
    input  logic                R0out,  R1out,  R2out,  R3out,
    input  logic                R4out,  R5out,  R6out,  R7out,
    input  logic                R8out,  R9out,  R10out, R11out,
    input  logic                R12out, R13out, R14out, R15out,
    input  logic                R0in,   R1in,   R2in,   R3in,
    input  logic                R4in,   R5in,   R6in,   R7in,
    input  logic                R8in,   R9in,   R10in,  R11in,
    input  logic                R12in,  R13in,  R14in,  R15in,
    input  logic                ADD, SUB, SHR, SHRA, SHL, ROR, ROL,
    input  logic                AND, OR, MUL, DIV, NEG, NOT,
    output logic [DATA_W-1:0]   BusMuxOut,
    output logic [DATA_W-1:0]   PC_q,
    output logic [DATA_W-1:0]   IR_q,
    output logic [DATA_W-1:0]   MAR_q,
    output logic [2*DATA_W-1:0] Z_q
);
    import datapath_pkg::*;

    logic [NUM_GPR-1:0] r_out, r_in;
    logic [NUM_OPS-1:0] op_strobes;
    logic [NUM_SRC-1:0] src_sel;
    logic [DATA_W-1:0]  src_val [NUM_SRC];
    logic [DATA_W-1:0]  bus;
    logic [2*DATA_W-1:0] alu_c;

    logic [DATA_W-1:0]   gp_q [NUM_GPR];
    logic [DATA_W-1:0]   gp_d [NUM_GPR];
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
    logic [DATA_W-1:0]   y_q, y_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [2*DATA_W-1:0] z_q, z_d;

    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign op_strobes = {NOT, NEG, DIV, MUL, OR, AND, ROL, ROR, SHL, SHRA, SHR, SUB, ADD};

    always_comb begin
        src_sel = '0;
        src_sel[SRC_R0 +: NUM_GPR] = r_out;
        src_sel[SRC_HI]  = HIout;
        src_sel[SRC_LO]  = LOout;
        src_sel[SRC_ZHI] = Zhighout;
        src_sel[SRC_ZLO] = Zlowout;
        src_sel[SRC_PC]  = PCout;
        src_sel[SRC_MDR] = MDRout;
    end

    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) src_val[SRC_R0 + i] = gp_q[i];
`ifdef DATAPATH_R0_ZERO_EN
        src_val[SRC_R0] = '0;
`endif
        src_val[SRC_HI]  = hi_q;
        src_val[SRC_LO]  = lo_q;
        src_val[SRC_ZHI] = z_q[2*DATA_W-1:DATA_W];
        src_val[SRC_ZLO] = z_q[DATA_W-1:0];
        src_val[SRC_PC]  = pc_q;
        src_val[SRC_MDR] = mdr_q;
    end

    // Scan from the lowest-priority source up so the lowest index wins.
    always_comb begin
        bus = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_sel[i]) bus = src_val[i];
        end
    end

    datapath_alu u_alu (
        .a          (y_q),
        .b          (bus),
        .op_strobes (op_strobes),
        .c          (alu_c)
    );

    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) gp_d[i] = r_in[i] ? bus : gp_q[i];
        hi_d  = HIin  ? bus : hi_q;
        lo_d  = LOin  ? bus : lo_q;
        pc_d  = PCin  ? bus : pc_q;
        ir_d  = IRin  ? bus : ir_q;
        y_d   = Yin   ? bus : y_q;
        mar_d = MARin ? bus : mar_q;
        mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
        z_d   = Zin   ? alu_c : z_q;
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < NUM_GPR; i++) gp_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= PC_RESET;
            ir_q  <= '0;
            y_q   <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) gp_q[i] <= gp_d[i];
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            y_q   <= y_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            z_q   <= z_d;
        end
    end

    assign BusMuxOut = bus;
    assign PC_q      = pc_q;
    assign IR_q      = ir_q;
    assign MAR_q     = mar_q;
    assign Z_q       = z_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the single-bus datapath with hand-computed expectations.
module tb_datapath;
    import datapath_pkg::*;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        HIin, HIout, LOin, LOout, PCin, PCout, IRin, Zin;
    logic        Zhighout, Zlowout, Yin, MARin, MDRin, MDRout, Read;
    logic [31:0] Mdatain;
    logic [15:0] r_out, r_in;
    logic [12:0] ops;
    logic [31:0] BusMuxOut, PC_q, IR_q, MAR_q;
    logic [63:0] Z_q;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clock = ~Clock;

    datapath dut (
        .Clock(Clock), .Clear(Clear),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .PCin(PCin), .PCout(PCout), .IRin(IRin), .Zin(Zin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .Yin(Yin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Mdatain(Mdatain),
        .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
        .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
        .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .R0in(r_in[0]),     .R1in(r_in[1]),     .R2in(r_in[2]),     .R3in(r_in[3]),
        .R4in(r_in[4]),     .R5in(r_in[5]),     .R6in(r_in[6]),     .R7in(r_in[7]),
        .R8in(r_in[8]),     .R9in(r_in[9]),     .R10in(r_in[10]),   .R11in(r_in[11]),
        .R12in(r_in[12]),   .R13in(r_in[13]),   .R14in(r_in[14]),   .R15in(r_in[15]),
        .ADD(ops[0]), .SUB(ops[1]), .SHR(ops[2]), .SHRA(ops[3]), .SHL(ops[4]),
        .ROR(ops[5]), .ROL(ops[6]), .AND(ops[7]), .OR(ops[8]), .MUL(ops[9]),
        .DIV(ops[10]), .NEG(ops[11]), .NOT(ops[12]),
        .BusMuxOut(BusMuxOut), .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q), .Z_q(Z_q)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        Clear = 0; HIin = 0; HIout = 0; LOin = 0; LOout = 0; PCin = 0; PCout = 0;
        IRin = 0; Zin = 0; Zhighout = 0; Zlowout = 0; Yin = 0; MARin = 0;
        MDRin = 0; MDRout = 0; Read = 0; r_out = '0; r_in = '0; ops = '0;
        #1;
    endtask

    task automatic mdr_load(input logic [31:0] v);
        idle();
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
        idle();
    endtask

    task automatic set_reg(input int idx, input logic [31:0] v);
        mdr_load(v);
        MDRout = 1; r_in[idx] = 1;
        tick();
        idle();
    endtask

    task automatic set_y(input logic [31:0] v);
        mdr_load(v);
        MDRout = 1; Yin = 1;
        tick();
        idle();
    endtask

    // Y <- a, bus <- b (through MDR), Z <- ALU result for the given strobe.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b);
        set_y(a);
        mdr_load(b);
        MDRout = 1; ops[op] = 1; Zin = 1;
        tick();
        idle();
    endtask

    task automatic bus_of_reg(input int idx, input string tag, input logic [31:0] exp);
        idle();
        r_out[idx] = 1;
        #1;
        chk(tag, {32'b0, BusMuxOut}, {32'b0, exp});
        idle();
    endtask

    initial begin
        Mdatain = '0;
        idle();
        Clear = 1;
        tick();
        idle();
        chk("reset_pc",  {32'b0, PC_q},  64'h0);
        chk("reset_ir",  {32'b0, IR_q},  64'h0);
        chk("reset_mar", {32'b0, MAR_q}, 64'h0);
        chk("reset_z",   Z_q,            64'h0);
        chk("bus_idle",  {32'b0, BusMuxOut}, 64'h0);

        // Load via MDR into R6
        Mdatain = 32'h12; Read = 1; MDRin = 1;
        tick();
        idle();
        MDRout = 1; r_in[6] = 1;
        tick();
        idle();
        bus_of_reg(6, "mdr_to_r6", 32'h0000_0012);

        // NOT of R7 into R6 through Z
        set_reg(7, 32'h14);
        r_out[7] = 1; ops[OP_NOT] = 1; Yin = 1; Zin = 1;
        tick();
        idle();
        chk("not_z_hi", {32'b0, Z_q[63:32]}, 64'h0);
        Zlowout = 1; r_in[6] = 1;
        tick();
        idle();
        bus_of_reg(6, "not_r6", 32'hFFFF_FFEB);

        // Instruction fetch
        Clear = 1;
        tick();
        idle();
        PCout = 1; MARin = 1; Zin = 1;
        tick();
        idle();
        chk("fetch_mar", {32'b0, MAR_q}, 64'h0);
        chk("fetch_z",   Z_q,            64'h1);
        Zlowout = 1; PCin = 1;
        tick();
        idle();
        chk("fetch_pc", {32'b0, PC_q}, 64'h1);
        mdr_load(32'h2891_8000);
        MDRout = 1; IRin = 1;
        tick();
        idle();
        chk("fetch_ir", {32'b0, IR_q}, 64'h2891_8000);

        // Simultaneous drive and load of PC: incremented value visible next cycle
        PCout = 1; PCin = 1; Zin = 1;
        #1;
        chk("pc_self_bus", {32'b0, BusMuxOut}, 64'h1);
        tick();
        idle();
        chk("pc_self_keep", {32'b0, PC_q}, 64'h1);
        chk("pc_self_z",    Z_q,            64'h2);

        // MUL / DIV
        run_op(OP_MUL, 32'hFFFF_FFFE, 32'h3);
        chk("mul_neg", Z_q, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(OP_DIV, 32'h7, 32'hFFFF_FFFE);
        chk("div_neg", Z_q, 64'h0000_0001_FFFF_FFFD);
        Zhighout = 1;
        #1;
        chk("zhigh_bus", {32'b0, BusMuxOut}, 64'h1);
        idle();
        run_op(OP_DIV, 32'h7, 32'h0);
        chk("div_zero", Z_q, 64'h0000_0007_FFFF_FFFF);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2);
        chk("div_rem_sign", Z_q, 64'hFFFF_FFFF_FFFF_FFFD);

        // Shifts and rotates
        run_op(OP_SHR,  32'h8000_0001, 32'h1); chk("shr",  Z_q, 64'h4000_0000);
        run_op(OP_SHRA, 32'h8000_0001, 32'h1); chk("shra", Z_q, 64'hC000_0000);
        run_op(OP_ROR,  32'h8000_0001, 32'h1); chk("ror",  Z_q, 64'hC000_0000);
        run_op(OP_ROL,  32'h8000_0001, 32'h1); chk("rol",  Z_q, 64'h0000_0003);
        run_op(OP_SHL,  32'h8000_0001, 32'h1); chk("shl",  Z_q, 64'h0000_0002);
        run_op(OP_ROL,  32'h1234_5678, 32'h20); chk("rol_by_32", Z_q, 64'h1234_5678);

        // Arithmetic and logic
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h2); chk("add_wrap", Z_q, 64'h1);
        run_op(OP_SUB, 32'h3, 32'h5);         chk("sub_wrap", Z_q, 64'hFFFF_FFFE);
        run_op(OP_AND, 32'hF0F0_1234, 32'hFF00_00FF); chk("and", Z_q, 64'hF000_0034);
        run_op(OP_OR,  32'hF0F0_1234, 32'h0F00_0001); chk("or",  Z_q, 64'hFFF0_1235);
        run_op(OP_NEG, 32'h0, 32'h1);         chk("neg", Z_q, 64'hFFFF_FFFF);

        // Op priority: ADD beats SUB
        set_y(32'h10);
        mdr_load(32'h3);
        MDRout = 1; ops[OP_ADD] = 1; ops[OP_SUB] = 1; Zin = 1;
        tick();
        idle();
        chk("op_priority", Z_q, 64'h13);

        // Bus priority
        set_reg(2, 32'hAAAA_0002);
        set_reg(9, 32'hBBBB_0009);
        set_reg(15, 32'hCCCC_000F);
        mdr_load(32'hDDDD_0010);
        MDRout = 1; HIin = 1;
        tick();
        idle();
        mdr_load(32'hEEEE_0011);
        MDRout = 1; LOin = 1;
        tick();
        idle();
        r_out[2] = 1; r_out[9] = 1; HIout = 1; MDRout = 1;
        #1;
        chk("prio_r2", {32'b0, BusMuxOut}, 64'hAAAA_0002);
        idle();
        r_out[15] = 1; HIout = 1; LOout = 1;
        #1;
        chk("prio_r15", {32'b0, BusMuxOut}, 64'hCCCC_000F);
        idle();
        HIout = 1; LOout = 1; PCout = 1;
        #1;
        chk("prio_hi", {32'b0, BusMuxOut}, 64'hDDDD_0010);
        idle();
        LOout = 1; MDRout = 1;
        #1;
        chk("prio_lo", {32'b0, BusMuxOut}, 64'hEEEE_0011);
        idle();

        // R0 as a bus source
        set_reg(0, 32'h0000_00A5);
`ifdef DATAPATH_R0_ZERO_EN
        bus_of_reg(0, "r0_source", 32'h0);
`else
        bus_of_reg(0, "r0_source", 32'h0000_00A5);
`endif

        // Clear overrides loads in the same cycle
        set_reg(5, 32'h55);
        run_op(OP_ADD, 32'h1, 32'h1);
        mdr_load(32'h77);
        MDRout = 1; IRin = 1; MARin = 1; PCin = 1;
        tick();
        idle();
        Clear = 1; r_in[5] = 1; MDRout = 1; IRin = 1; Zin = 1;
        tick();
        idle();
        bus_of_reg(5, "clear_r5", 32'h0);
        bus_of_reg(2, "clear_r2", 32'h0);
        chk("clear_pc",  {32'b0, PC_q},  64'h0);
        chk("clear_ir",  {32'b0, IR_q},  64'h0);
        chk("clear_mar", {32'b0, MAR_q}, 64'h0);
        chk("clear_z",   Z_q,            64'h0);
        MDRout = 1; #1; chk("clear_mdr", {32'b0, BusMuxOut}, 64'h0); idle();
        HIout = 1;  #1; chk("clear_hi",  {32'b0, BusMuxOut}, 64'h0); idle();
        chk("bus_idle_end", {32'b0, BusMuxOut}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
